h264coretransform_scheduler: RTL

Sequences the 4x4 residual blocks of one macroblock through the H.264 core transform. Reads rows from the upstream residual buffer and issues them to the transform as 4-cycle ENABLE bursts, gated by the transform's READY. Labels each returned coefficient with its block and zigzag index, and signals completion of the macroblock. Sits between the residual buffer and the quantiser, wrapping one `h264coretransform` instance.

---
 rtl/h264coretransform_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/h264coretransform_scheduler.sv
`default_nettype none
// h264coretransform_scheduler: feeds the NBLK 4x4 residual blocks of one macroblock to the core
// transform in 4-row bursts and tags returned coefficients. Optional checker: H264_CT_SCHED_ERR_EN.
module h264coretransform_scheduler #(
  parameter int NBLK = 24
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ROW_REQ,
  output logic [6:0]  ROW_ADDR,
  input  logic [35:0] ROW_DATA,
  input  logic        XT_READY,
  output logic        XT_ENABLE,
  output logic [35:0] XT_XXIN,
  input  logic        XT_VALID,
  input  logic [13:0] XT_YNOUT,
  output logic        COEF_VALID,
  output logic [13:0] COEF_OUT,
  output logic [4:0]  COEF_BLK,
  output logic [3:0]  COEF_IDX,
  output logic        ERR
);

  localparam logic [5:0] C_NBLK = 6'(NBLK);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FEED  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_row;
  logic [1:0]  r_hold;
  logic [5:0]  r_in_blk;
  logic [5:0]  r_out_blk;
  logic [3:0]  r_out_idx;
  logic        r_done;
  logic        r_enable;
  logic        r_coef_valid;
  logic [13:0] r_coef_out;
  logic [4:0]  r_coef_blk;
  logic [3:0]  r_coef_idx;

  logic        w_start_ok;
  logic        w_clear;
  logic        w_feed_last;
  logic        w_drain_done;
  logic        w_out_blk_ok;

  // DONE is registered, so the IDLE cycle that carries it must still refuse START.
  assign w_start_ok   = START && !r_done;
  assign w_clear      = (r_state == S_IDLE) && w_start_ok;
  assign w_feed_last  = (r_state == S_FEED) && (r_row == 2'd3);
  assign w_drain_done = (r_state == S_DRAIN) && (r_out_blk == C_NBLK);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_WAIT;
      S_WAIT:  if (XT_READY) w_next = S_FEED;
      S_FEED:  if (r_row == 2'd3) w_next = S_HOLD;
      S_HOLD:  if (r_hold == 2'd2) w_next = (r_in_blk < C_NBLK) ? S_WAIT : S_DRAIN;
      S_DRAIN: if (r_out_blk == C_NBLK) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_row    <= 2'd0;
      r_hold   <= 2'd0;
      r_in_blk <= 6'd0;
      r_done   <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      if (w_clear)          r_in_blk <= 6'd0;
      else if (w_feed_last) r_in_blk <= r_in_blk + 6'd1;
      r_row    <= (r_state == S_FEED) ? r_row + 2'd1 : 2'd0;
      r_hold   <= (r_state == S_HOLD) ? r_hold + 2'd1 : 2'd0;
      r_done   <= w_drain_done;
      r_enable <= (r_state == S_FEED);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out_blk    <= 6'd0;
      r_out_idx    <= 4'd0;
      r_coef_valid <= 1'b0;
      r_coef_out   <= 14'd0;
      r_coef_blk   <= 5'd0;
      r_coef_idx   <= 4'd0;
    end else begin
      r_coef_valid <= XT_VALID;
      if (XT_VALID) begin
        r_coef_out <= XT_YNOUT;
        r_coef_blk <= r_out_blk[4:0];
        r_coef_idx <= r_out_idx;
      end
      if (w_clear) begin
        r_out_blk <= 6'd0;
        r_out_idx <= 4'd0;
      end else if (XT_VALID) begin
        r_out_idx <= r_out_idx + 4'd1;
        if ((r_out_idx == 4'd15) && w_out_blk_ok) r_out_blk <= r_out_blk + 6'd1;
      end
    end
  end

`ifdef H264_CT_SCHED_ERR_EN
  logic r_err;
  logic w_err_hit;

  // A beat with no block outstanding, or any beat while idle, is a protocol violation.
  assign w_err_hit    = XT_VALID && ((r_out_blk == r_in_blk) || (r_state == S_IDLE));
  assign w_out_blk_ok = (r_out_blk < C_NBLK);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_err <= 1'b0;
    else          r_err <= r_err | w_err_hit;
  end

  assign ERR = r_err;
`else
  assign w_out_blk_ok = 1'b1;
  assign ERR          = 1'b0;
`endif

  assign BUSY       = (r_state != S_IDLE);
  assign DONE       = r_done;
  assign ROW_REQ    = (r_state == S_FEED);
  assign ROW_ADDR   = (r_state == S_FEED) ? {r_in_blk[4:0], r_row} : 7'd0;
  assign XT_ENABLE  = r_enable;
  assign XT_XXIN    = ROW_DATA;
  assign COEF_VALID = r_coef_valid;
  assign COEF_OUT   = r_coef_out;
  assign COEF_BLK   = r_coef_blk;
  assign COEF_IDX   = r_coef_idx;

endmodule
`default_nettype wire
